muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage of the pipeline. It executes signed and unsigned multiply, multiply-accumulate, multiply-subtract and divide one bit per cycle over a DATA_W-wide datapath. Results are returned as a double-width {HI,LO} pair under a start/ready handshake. The EX stage holds the pipeline stalled while busy_o is high and can annul an in-flight operation.

## Interface
- DATA_W, 32: operand width; result is 2*DATA_W; legal values are 8 to 64, even.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request a new operation; sampled only in IDLE.
- annul_i  in  1  abort the current operation; wins over start_i.
- op_i  in  3  operation select:
  - 000 MULT, 001 MULTU
  - 010 DIV, 011 DIVU
  - 100 MADD, 101 MADDU
  - 110 MSUB, 111 MSUBU
  - 111 is MSUBU; all eight codes are defined.
- opdata1_i  in  DATA_W  multiplicand / dividend.
- opdata2_i  in  DATA_W  multiplier / divisor.
- hi_i, lo_i  in  DATA_W each  accumulator for MADD/MSUB, already forwarded by EX.
- result_o  out  2*DATA_W  {HI,LO}; for divide, HI = remainder, LO = quotient.
- ready_o  out  1  one-cycle pulse; result_o and div_zero_o are valid in that cycle.
- busy_o  out  1  high in every state except IDLE.
- div_zero_o  out  1  the last completed divide had a zero divisor.

## Operation
- States are IDLE, MUL, DIV, ACC and DONE.
- Accept: in IDLE, with start_i=1 and annul_i=0, the unit does the following at the accept edge E0:
  - registers op_i, both operands and {hi_i,lo_i};
  - for signed ops, converts operands to magnitudes and records the result sign(s);
  - clears div_zero_o;
  - zeroes the iteration counter;
  - moves to MUL or DIV.
- Divide by zero: divisor == 0 at E0 moves directly to DONE with result {0,0} and div_zero_o=1.
- MUL: shift-add over the magnitudes, one multiplier bit per cycle, DATA_W cycles. On the last iteration:
  - the sign correction (two's-complement negate when the operand signs differ, signed ops only) is applied;
  - the next state is DONE for MULT/MULTU and ACC for MADD/MSUB variants.
- ACC: one cycle.
  - MADD/MADDU: {HI,LO} + product.
  - MSUB/MSUBU: {HI,LO} − product.
  - Arithmetic is modulo 2^(2*DATA_W); no overflow flag.
  - Next state is DONE.
- DIV: restoring division, one quotient bit per cycle, DATA_W cycles.
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - The most-negative dividend divided by −1 gives quotient −2^(DATA_W−1) (wraps) and remainder 0.
  - Next state is DONE.
- DONE: ready_o=1 for this single cycle; next state is IDLE unconditionally. start_i in DONE is ignored.
- result_o is written only on entry to DONE and holds until the next entry to DONE. Annul and a new accept do not change it.
- Annul: annul_i=1 in MUL, DIV, ACC or DONE returns the unit to IDLE at the next edge.
  - No ready_o pulse is produced; if annul_i arrives in DONE, the pulse in that cycle still occurs.
  - div_zero_o keeps its value.
- start_i while busy is ignored; requests are not queued.
- Operand inputs are don't-care after E0.

## Timing
- Reset (rst=0, takes effect immediately):
  - state IDLE, counter 0;
  - result_o 0, ready_o 0, busy_o 0, div_zero_o 0;
  - an in-flight operation is lost and no pulse is produced.
- Latency, counted from the accept edge E0 to the cycle in which ready_o is high:
  - MULT, MULTU, DIV, DIVU: the cycle after edge E0+DATA_W+1 (33 cycles at DATA_W=32).
  - MADD/MSUB variants: the cycle after edge E0+DATA_W+2.
  - Divide by zero: the cycle after edge E0+1.
- busy_o rises the cycle after E0 and falls the cycle after the ready_o pulse.
- The earliest back-to-back accept is the first IDLE cycle after DONE, which gives a throughput of one operation per latency+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULT: −3 × 7, DATA_W=32 → result_o=0xFFFFFFFF_FFFFFFEB; ready_o high exactly once, 33 cycles after accept.
- Divide signs:
  - DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 / 2 → LO=3, HI=1.
  - DIV 7 / −2 → LO=0xFFFFFFFD, HI=1.
- DIV 5 / 0 → ready_o in the cycle after E0+1, result_o=0, div_zero_o=1. A following MULTU 2 × 3 clears div_zero_o at its accept and returns 6.
- MSUB with hi_i:lo_i=0:10, operands 3 × 4 → 0xFFFFFFFF_FFFFFFFE, ready after 34 cycles. MADDU with hi_i:lo_i=0xFFFFFFFF:0xFFFFFFFF, operands 1 × 1 → 0 (wrap).
- Annul and back-to-back:
  - Annul asserted at iteration 10 of a MULT → no ready_o, busy_o low next cycle, result_o unchanged.
  - Then MULTU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001.
  - start_i held high throughout the MULTU is accepted only once.
- Reset during DIV (rst low for 1 cycle) → all outputs 0 immediately and no pulse. DATA_W=8 instance: DIV 0x80 / 0xFF → LO=0x80, HI=0x00, ready after 9 cycles.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative multiply / multiply-accumulate / divide unit for the EX stage.
// One multiplier or quotient bit per cycle; results returned as {HI,LO} under start/ready.
module muldiv_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  div_zero_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int RES_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_ACC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  opnd_q, opnd_d;
    logic [RES_W-1:0]   work_q, work_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic               is_acc_q, is_acc_d;
    logic               is_sub_q, is_sub_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [RES_W-1:0]   result_q;
    logic               ready_q;
    logic               busy_q;

    logic               res_we;
    logic [RES_W-1:0]   res_val;

    // Operand decode at accept: signed ops work on magnitudes and remember the signs.
    logic               in_div, in_signed, in_neg1, in_neg2;
    logic [DATA_W-1:0]  mag1, mag2;

    assign in_div    = (op_i[2:1] == 2'b01);
    assign in_signed = ~op_i[0];
    assign in_neg1   = in_signed & opdata1_i[DATA_W-1];
    assign in_neg2   = in_signed & opdata2_i[DATA_W-1];
    assign mag1      = in_neg1 ? -opdata1_i : opdata1_i;
    assign mag2      = in_neg2 ? -opdata2_i : opdata2_i;

    logic               last_iter;
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

    // Shift-add step: work holds {partial product high, remaining multiplier bits}.
    logic [DATA_W:0]    mul_sum;
    logic [RES_W-1:0]   mul_next, mul_fixed;

    assign mul_sum   = {1'b0, work_q[RES_W-1:DATA_W]} + {1'b0, (work_q[0] ? opnd_q : '0)};
    assign mul_next  = {mul_sum, work_q[DATA_W-1:1]};
    assign mul_fixed = qneg_q ? -mul_next : mul_next;

    // Restoring step: work holds {partial remainder, dividend bits becoming quotient bits}.
    logic [DATA_W:0]    div_shift;
    logic               div_ge;
    logic [DATA_W-1:0]  div_diff, div_rem, div_quo, div_rem_fin;
    logic [RES_W-1:0]   div_next, div_fixed;

    assign div_shift   = {work_q[RES_W-1:DATA_W], work_q[DATA_W-1]};
    assign div_ge      = (div_shift >= {1'b0, opnd_q});
    assign div_diff    = div_shift[DATA_W-1:0] - opnd_q;
    assign div_rem     = div_ge ? div_diff : div_shift[DATA_W-1:0];
    assign div_next    = {div_rem, work_q[DATA_W-2:0], div_ge};
    assign div_quo     = div_next[DATA_W-1:0];
    assign div_rem_fin = div_next[RES_W-1:DATA_W];
    assign div_fixed   = {(rneg_q ? -div_rem_fin : div_rem_fin), (qneg_q ? -div_quo : div_quo)};

    logic [RES_W-1:0]   acc_res;
    assign acc_res = is_sub_q ? (acc_q - work_q) : (acc_q + work_q);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        work_d   = work_q;
        acc_d    = acc_q;
        is_acc_d = is_acc_q;
        is_sub_d = is_sub_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        res_we   = 1'b0;
        res_val  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    opnd_d   = in_div ? mag2 : mag1;
                    work_d   = {{DATA_W{1'b0}}, (in_div ? mag1 : mag2)};
                    acc_d    = {hi_i, lo_i};
                    is_acc_d = op_i[2];
                    is_sub_d = op_i[2] & op_i[1];
                    qneg_d   = in_neg1 ^ in_neg2;
                    rneg_d   = in_neg1;
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    if (in_div && (opdata2_i == '0)) begin
                        dz_d    = 1'b1;
                        res_we  = 1'b1;
                        res_val = '0;
                        state_d = S_DONE;
                    end else if (in_div) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                cnt_d  = cnt_q + CNT_W'(1);
                work_d = mul_next;
                if (last_iter) begin
                    work_d = mul_fixed;
                    if (is_acc_q) begin
                        state_d = S_ACC;
                    end else begin
                        res_we  = 1'b1;
                        res_val = mul_fixed;
                        state_d = S_DONE;
                    end
                end
            end
            S_DIV: begin
                cnt_d  = cnt_q + CNT_W'(1);
                work_d = div_next;
                if (last_iter) begin
                    res_we  = 1'b1;
                    res_val = div_fixed;
                    state_d = S_DONE;
                end
            end
            S_ACC: begin
                res_we  = 1'b1;
                res_val = acc_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An annulled operation never writes the result and never pulses ready.
        if (annul_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            res_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            work_q   <= '0;
            acc_q    <= '0;
            is_acc_q <= 1'b0;
            is_sub_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            is_acc_q <= is_acc_d;
            is_sub_q <= is_sub_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            if (res_we) begin
                result_q <= res_val;
            end
            ready_q  <= (state_q == S_DONE);
            busy_q   <= (state_d != S_IDLE) || (state_q == S_DONE);
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign busy_o     = busy_q;
    assign div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed vector table, multi-cycle corner sequences,
// and random operations compared against a plain-arithmetic reference model.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0, annul = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0, hi = '0, lo = '0;
    logic [63:0] res;
    logic        ready, busy, dz;

    logic        start8 = 1'b0, annul8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, hi8 = '0, lo8 = '0;
    logic [15:0] res8;
    logic        ready8, busy8, dz8;

    int checks = 0;
    int errors = 0;

    muldiv_iter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op),
        .opdata1_i(a), .opdata2_i(b), .hi_i(hi), .lo_i(lo),
        .result_o(res), .ready_o(ready), .busy_o(busy), .div_zero_o(dz)
    );

    muldiv_iter #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .op_i(op8),
        .opdata1_i(a8), .opdata2_i(b8), .hi_i(hi8), .lo_i(lo8),
        .result_o(res8), .ready_o(ready8), .busy_o(busy8), .div_zero_o(dz8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic straight from the operation definitions.
    function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        longint      sx, sy, q, m, p;
        logic [63:0] r;
        logic        z;
        sx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
        sy = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
        p  = sx * sy;
        z  = 1'b0;
        r  = '0;
        case (o)
            3'b000, 3'b001: r = p;
            3'b010, 3'b011: begin
                if (y == 32'd0) begin
                    z = 1'b1;
                end else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            3'b100, 3'b101: r = {h, l} + 64'(p);
            default:        r = {h, l} - 64'(p);
        endcase
        return {z, r};
    endfunction

    task automatic run_op(input logic w8, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] h, input logic [31:0] l,
                          output logic [63:0] r, output logic z, output int lat);
        if (w8) begin
            op8 = o; a8 = x[7:0]; b8 = y[7:0]; hi8 = h[7:0]; lo8 = l[7:0]; start8 = 1'b1;
        end else begin
            op = o; a = x; b = y; hi = h; lo = l; start = 1'b1;
        end
        tick();
        start  = 1'b0;
        start8 = 1'b0;
        check("busy_rise", w8 ? busy8 : busy, 64'd1);
        lat = -1;
        r   = '0;
        z   = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if ((w8 ? ready8 : ready) == 1'b1) begin
                lat = k;
                r   = w8 ? {48'b0, res8} : res;
                z   = w8 ? dz8 : dz;
                break;
            end
        end
    endtask

    typedef struct {
        logic        w8;
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        logic        dz;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin : main
        logic [63:0] r, last32;
        logic        z;
        int          lat, pulses, pulse_k;
        logic [64:0] m;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic        seen;

        vecs[0]  = '{1'b0, 3'b000, 32'hFFFFFFFD, 32'd7,        32'd0,        32'd0,        64'hFFFFFFFF_FFFFFFEB, 1'b0, 33};
        vecs[1]  = '{1'b0, 3'b010, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 33};
        vecs[2]  = '{1'b0, 3'b011, 32'd7,        32'd2,        32'd0,        32'd0,        64'h00000001_00000003, 1'b0, 33};
        vecs[3]  = '{1'b0, 3'b010, 32'd7,        32'hFFFFFFFE, 32'd0,        32'd0,        64'h00000001_FFFFFFFD, 1'b0, 33};
        vecs[4]  = '{1'b0, 3'b010, 32'd5,        32'd0,        32'd0,        32'd0,        64'h0,                 1'b1, 1};
        vecs[5]  = '{1'b0, 3'b001, 32'd2,        32'd3,        32'd0,        32'd0,        64'd6,                 1'b0, 33};
        vecs[6]  = '{1'b0, 3'b110, 32'd3,        32'd4,        32'd0,        32'd10,       64'hFFFFFFFF_FFFFFFFE, 1'b0, 34};
        vecs[7]  = '{1'b0, 3'b101, 32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                 1'b0, 34};
        vecs[8]  = '{1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        64'hFFFFFFFE_00000001, 1'b0, 33};
        vecs[9]  = '{1'b0, 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,        64'h00000000_80000000, 1'b0, 33};
        vecs[10] = '{1'b0, 3'b100, 32'hFFFFFFFE, 32'd3,        32'd0,        32'd5,        64'hFFFFFFFF_FFFFFFFF, 1'b0, 34};
        vecs[11] = '{1'b0, 3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd0,        32'd0,        64'hFFFFFFFE_00000002, 1'b0, 33};
        vecs[12] = '{1'b1, 3'b010, 32'h80,       32'hFF,       32'd0,        32'd0,        64'h0080,              1'b0, 9};
        vecs[13] = '{1'b1, 3'b011, 32'd200,      32'd7,        32'd0,        32'd0,        64'h041C,              1'b0, 9};
        vecs[14] = '{1'b1, 3'b000, 32'h80,       32'h80,       32'd0,        32'd0,        64'h4000,              1'b0, 9};
        vecs[15] = '{1'b1, 3'b111, 32'hFF,       32'hFF,       32'd0,        32'd0,        64'h01FF,              1'b0, 10};

        // Reset state
        #12;
        check("rst_result", res, 64'd0);
        check("rst_ready", ready, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_dz", dz, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Directed vectors, issued back-to-back
        last32 = '0;
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, r, z, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp);
            check($sformatf("vec%0d_dz", i), z, vecs[i].dz);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            if (!vecs[i].w8) last32 = vecs[i].exp;
        end

        // Annul at iteration 10 of a MULT
        op = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        annul = 1'b1;
        tick();
        annul = 1'b0;
        check("annul_busy_low", busy, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (ready) seen = 1'b1;
        end
        check("annul_no_ready", seen, 64'd0);
        check("annul_result_kept", res, last32);

        // start_i held high throughout a MULTU: accepted once
        op = 3'b001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        pulses  = 0;
        pulse_k = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (ready) begin
                pulses++;
                if (pulses == 1) begin
                    pulse_k = k;
                    check("held_result", res, 64'hFFFFFFFE_00000001);
                    check("held_busy_in_ready", busy, 64'd1);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held_pulses", 64'(pulses), 64'd1);
        check("held_latency", 64'(pulse_k), 64'd33);
        check("held_busy_end", busy, 64'd0);

        // Reset in the middle of a DIV
        op = 3'b010; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("midrst_result", res, 64'd0);
        check("midrst_ready", ready, 64'd0);
        check("midrst_busy", busy, 64'd0);
        check("midrst_dz", dz, 64'd0);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            tick();
            if (ready) seen = 1'b1;
        end
        check("midrst_no_ready", seen, 64'd0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 9) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 5));
                2:       rb = 32'hFFFFFFFF;
                default: rb = 32'($urandom);
            endcase
            hi = 32'($urandom);
            lo = 32'($urandom);
            m = model(ro, ra, rb, hi, lo);
            run_op(1'b0, ro, ra, rb, hi, lo, r, z, lat);
            check($sformatf("rnd%0d_op%0d_result", i, ro), r, m[63:0]);
            check($sformatf("rnd%0d_dz", i), z, m[64]);
            check($sformatf("rnd%0d_latency", i), 64'(lat),
                  (ro[2:1] == 2'b01 && rb == 32'd0) ? 64'd1 : (ro[2] ? 64'd34 : 64'd33));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
